mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port unified memory between the CPU's instruction-fetch (IF) port and its
//  load/store data (D) port. Grants one requester per transaction, drives the memory for a fixed
//  LATENCY-cycle access and returns read data with a one-cycle ready pulse.
//  Sits between the PC/fetch logic, the MEM stage and the memory model.
// PARAMETERS
//  ADDR_W   16  address width
//  DATA_W   16  data width
//  LATENCY  4   memory access cycles, >=1; mem_en held for exactly LATENCY cycles per access
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  if_req     in   1       fetch request; held high until if_rdy
//  if_addr    in   ADDR_W  fetch address; stable while if_req high
//  if_rdy     out  1       one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DATA_W  fetched word; held until next IF read completes
//  d_req      in   1       data request; held high until d_rdy
//  d_wr       in   1       1=store, 0=load; stable while d_req high
//  d_addr     in   ADDR_W  data address; stable while d_req high
//  d_wdata    in   DATA_W  store data; stable while d_req high
//  d_rdy      out  1       one-cycle pulse: data access complete
//  d_rdata    out  DATA_W  load data; held until next D read completes
//  mem_en     out  1       memory enable
//  mem_wr     out  1       memory write strobe
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid on last ACCESS cycle
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, owner IF, last_owner IF; every output 0.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE, all registered.
//  - IDLE: any req high -> latch owner, addr, wr (IF: wr=0), wdata; cnt<=LATENCY-1; go ACCESS.
//  - ACCESS: mem_en=1, mem_addr/mem_wr/mem_wdata from latched regs; cnt decrements; at cnt==0
//    capture mem_rdata into owner's rdata reg (reads only; stores leave d_rdata unchanged); go RESP.
//  - RESP: owner's rdy=1 for exactly this cycle; mem_en=0; go IDLE. Requester drops req next edge.
//  - Latency: req sampled in IDLE at cycle N -> rdy at cycle N+LATENCY+1; throughput LATENCY+2 per access.
//  - Requests arriving while busy wait (req held); no queueing, no abort by requester.
//  - Tie in IDLE (both req): see CONFIGURATION. Single requester always granted.
//  - mem outputs 0 outside ACCESS; if_rdy and d_rdy never high in the same cycle.
//  - rst mid-ACCESS/RESP: next edge IDLE, mem_en 0, transaction dropped, no rdy pulse, rdata regs 0.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin on ties; grant requester != last_owner, update last_owner on
//    each grant (reset last_owner=IF, so first tie goes to D).
//  Not defined: fixed priority, D always wins ties (load/store before fetch); last_owner omitted.
// STRUCTURE
//  mem_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_RESP}; owner_t {OWN_IF, OWN_D};
//    default LATENCY constant.
//  Sub-module arb_lat_cnt: loadable down-counter (load LATENCY-1, dec, zero flag); FSM and datapath
//    latches stay in mem_arbiter.
// TESTING (LATENCY=4)
//  1 IF only: if_req=1, if_addr=0x0010 sampled cycle 1, mem_rdata=0xA5A5 -> mem_en cycles 2-5 addr
//    0x0010, if_rdy cycle 6, if_rdata=0xA5A5, d_rdy stays 0.
//  2 Store: d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> mem_wr=1 and mem_wdata=0x1234 for 4
//    cycles, single d_rdy pulse, d_rdata unchanged.
//  3 Tie, fixed priority: both req in same IDLE cycle -> D served first (d_rdy cycle 6), IF next
//    (if_rdy cycle 12); D re-requesting every IDLE starves IF.
//  4 Tie, MEM_ARB_RR_EN: both held continuously -> grants alternate D, IF, D, IF.
//  5 Reset mid-ACCESS: rst=1 at cycle 3 of IF read -> cycle 4 IDLE, mem_en=0, busy=0, no if_rdy.
//  6 Back-to-back loads 0x0100 then 0x0101 -> d_rdy at cycles 6 and 12, d_rdata updates each time.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states (idle, memory access, response pulse)
//   owner_t     : which requester owns the current transaction
//   DEFAULT_LATENCY : default number of memory access cycles
//   cnt_width() : width of the latency down-counter for a given latency
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam int DEFAULT_LATENCY = 4;

  // A latency of 1 still needs a one-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/arb_lat_cnt.sv
// arb_lat_cnt: loadable down-counter that times one memory access.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset (count cleared to 0)
//   load in  load LATENCY-1 (start of an access)
//   dec  in  decrement by one (saturates at 0)
//   zero out count is 0, i.e. this is the last access cycle
module arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] cnt;

  // Load takes priority so a new access always starts from a full count;
  // decrement stops at zero so the counter never wraps while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port unified memory between the instruction
// fetch (IF) port and the load/store data (D) port. One requester is granted
// per transaction; the memory is driven for LATENCY cycles, then the owner
// gets a one-cycle ready pulse with read data held until its next read.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   if_req/if_addr      fetch request and address (held until if_rdy)
//   if_rdy/if_rdata     fetch done pulse and fetched word
//   d_req/d_wr/d_addr/d_wdata  data request, store flag, address, store data
//   d_rdy/d_rdata       data done pulse and load data
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata  memory interface
//   busy                high whenever the arbiter is not idle
// Configuration:
//   MEM_ARB_RR_EN defined   : round-robin between IF and D on ties
//   MEM_ARB_RR_EN undefined : fixed priority, D wins ties
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state;
  owner_t     owner;
`ifdef MEM_ARB_RR_EN
  owner_t     last_owner;
`endif

  logic grant_d;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // Decide who wins when the arbiter is idle. A lone requester always wins;
  // only the tie case depends on the arbitration policy.
  always_comb begin
    grant_d = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (d_req && if_req) begin
      grant_d = (last_owner == OWN_IF);
    end else begin
      grant_d = d_req;
    end
`else
    grant_d = d_req;
`endif
  end

  assign cnt_load = (state == ARB_IDLE) && (if_req || d_req);
  assign cnt_dec  = (state == ARB_ACCESS) && !cnt_zero;

  arb_lat_cnt #(
    .LATENCY(LATENCY)
  ) u_lat_cnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .zero(cnt_zero)
  );

  // Arbiter FSM. The mem_* registers double as the latched request, so they
  // are loaded on grant and cleared when the access ends, which keeps the
  // memory interface at zero outside ACCESS. Read data is captured on the
  // last access cycle, together with raising the owner's ready pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
`ifdef MEM_ARB_RR_EN
      last_owner <= OWN_IF;
`endif
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdy     <= 1'b0;
      d_rdy      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (if_req || d_req) begin
            state  <= ARB_ACCESS;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            if (grant_d) begin
              owner     <= OWN_D;
              mem_wr    <= d_wr;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              owner     <= OWN_IF;
              mem_wr    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
`ifdef MEM_ARB_RR_EN
            last_owner <= grant_d ? OWN_D : OWN_IF;
`endif
          end
        end
        ARB_ACCESS: begin
          if (cnt_zero) begin
            state     <= ARB_RESP;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (owner == OWN_D) begin
              d_rdy <= 1'b1;
              if (!mem_wr) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              if_rdy   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        ARB_RESP: begin
          state  <= ARB_IDLE;
          busy   <= 1'b0;
          if_rdy <= 1'b0;
          d_rdy  <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with LATENCY=4.
// Requesters push expected responses into per-port queues when they issue;
// a monitor pops and compares on every ready pulse. Expectations follow the
// build: MEM_ARB_RR_EN selects the round-robin tie ordering.
module tb_mem_arbiter;

  localparam int LAT = 4;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_rdy;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_rdy;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int   cyc;
  int   en_run;
  int   tests_run;
  int   tests_failed;
  exp_t if_q[$];
  exp_t d_q[$];

  mem_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdy   (if_rdy),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdy    (d_rdy),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle number and a count of consecutive mem_en cycles,
  // used to present read data only on the last access cycle.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    en_run <= mem_en ? en_run + 1 : 0;
  end

  // Fixed memory contents for the addresses the stimulus reads.
  function automatic logic [15:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hA5A5;
      16'h0020: return 16'h3333;
      16'h0100: return 16'h1111;
      16'h0101: return 16'h2222;
      16'h0300: return 16'h4444;
      default:  return 16'hBEEF;
    endcase
  endfunction

  assign mem_rdata = (mem_en && en_run == LAT - 1) ? mem_model(mem_addr) : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One requester transaction: raise req, push the expected response
  // (data and the cycle its ready pulse must appear), wait for ready,
  // then drop req on the following edge. Must be called just after a posedge.
  task automatic applyStimulus(input logic is_d, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp_data,
                               input int delay);
    exp_t e;
    int   n;
    e.data = exp_data;
    e.cyc  = cyc + delay;
    if (is_d) begin
      d_q.push_back(e);
      d_req   = 1'b1;
      d_wr    = wr;
      d_addr  = addr;
      d_wdata = wdata;
    end else begin
      if_q.push_back(e);
      if_req  = 1'b1;
      if_addr = addr;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_rdy : if_rdy) && n < 60);
    if (!(is_d ? d_rdy : if_rdy)) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s timeout: got no rdy after %0d cycles, expected rdy", is_d ? "d" : "if", n);
    end
    @(posedge clk);
    #1;
    if (is_d) begin
      d_req   = 1'b0;
      d_wr    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
    end else begin
      if_req  = 1'b0;
      if_addr = '0;
    end
  endtask

  // Memory-side view of one uncontended access issued in the current cycle:
  // idle cycle, LATENCY enabled cycles with the latched request, then RESP.
  task automatic check_window(input string tag, input logic [15:0] addr, input logic wr,
                              input logic [15:0] wdata);
    @(negedge clk);
    checkOutput({tag, " idle"}, 64'({mem_en, mem_wr, busy}), 64'(3'b000));
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      checkOutput({tag, " access"}, 64'({mem_en, mem_wr, mem_addr, mem_wdata, busy}),
                  64'({1'b1, wr, addr, wdata, 1'b1}));
    end
    @(negedge clk);
    checkOutput({tag, " resp"}, 64'({mem_en, mem_wr, mem_addr, mem_wdata, busy}),
                64'({1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1}));
  endtask

  // Monitor: every ready pulse is matched against the head of its port queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rdy || d_rdy) begin
        checkOutput("rdy exclusive", 64'(if_rdy & d_rdy), 64'(0));
      end
      if (if_rdy) begin
        if (if_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected if_rdy: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = if_q.pop_front();
          checkOutput("if_rdy cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("if_rdata", 64'(if_rdata), 64'(e.data));
        end
      end
      if (d_rdy) begin
        if (d_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected d_rdy: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = d_q.pop_front();
          checkOutput("d_rdy cycle", 64'(cyc), 64'(e.cyc));
          checkOutput("d_rdata", 64'(d_rdata), 64'(e.data));
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc          = 0;
    en_run       = 0;
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    if_req       = 1'b0;
    if_addr      = '0;
    d_req        = 1'b0;
    d_wr         = 1'b0;
    d_addr       = '0;
    d_wdata      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: every output zero
    @(negedge clk);
    checkOutput("reset ctrl", 64'({busy, mem_en, mem_wr, if_rdy, d_rdy}), 64'(0));
    checkOutput("reset mem bus", 64'({mem_addr, mem_wdata}), 64'(0));
    checkOutput("reset rdata", 64'({if_rdata, d_rdata}), 64'(0));

    // Fetch only: rdy LATENCY+1 cycles after issue with 0xA5A5
    @(posedge clk);
    #1;
    fork
      applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 5);
      check_window("fetch", 16'h0010, 1'b0, 16'h0000);
    join

    // Back-to-back loads: second request sampled in the IDLE right after RESP
    fork
      begin
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1111, 5);
        applyStimulus(1'b1, 1'b0, 16'h0101, 16'h0000, 16'h2222, 5);
      end
      begin
        check_window("load0", 16'h0100, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        check_window("load1", 16'h0101, 1'b0, 16'h0000);
      end
    join

    // Store: write strobe for the whole access, d_rdata keeps the last load
    fork
      applyStimulus(1'b1, 1'b1, 16'h0200, 16'h1234, 16'h2222, 5);
      check_window("store", 16'h0200, 1'b1, 16'h1234);
    join

    // Reset during an access: next cycle idle, no ready, read data cleared
    if_req  = 1'b1;
    if_addr = 16'h0010;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst mid ctrl", 64'({mem_en, busy, if_rdy, d_rdy}), 64'(0));
    checkOutput("rst mid rdata", 64'({if_rdata, d_rdata}), 64'(0));
    repeat (8) @(negedge clk);

    // Tie: IF held throughout, D issues three loads back-to-back
    @(posedge clk);
    #1;
    fork
`ifdef MEM_ARB_RR_EN
      applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h3333, 11);
`else
      applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h3333, 23);
`endif
      begin
        applyStimulus(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1111, 5);
`ifdef MEM_ARB_RR_EN
        applyStimulus(1'b1, 1'b0, 16'h0101, 16'h0000, 16'h2222, 11);
`else
        applyStimulus(1'b1, 1'b0, 16'h0101, 16'h0000, 16'h2222, 5);
`endif
        applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h4444, 5);
      end
    join

    repeat (3) @(negedge clk);
    checkOutput("if queue drained", 64'(if_q.size()), 64'(0));
    checkOutput("d queue drained", 64'(d_q.size()), 64'(0));
    checkOutput("final idle", 64'({busy, mem_en}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
